// File: rtl/wave_generator.sv
// rtl/wave_generator.sv - Tick-stepped phase accumulator producing saw/triangle/square/(sine or falling saw) samples.
// Optional macro WAVE_GEN_SINE_EN replaces the wave_sel=11 falling saw with a quarter-wave sine ROM.
module wave_generator #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick_in,
    input  logic         en,
    input  logic         clr,
    input  logic [1:0]   wave_sel,
    output logic [N-1:0] sample,
    output logic         sample_valid,
    output logic         phase_wrap
);

    logic         tick_prev;
    logic [N-1:0] phase;
    logic [N-1:0] phase_next;
    logic [N-1:0] tri_val;
    logic [N-1:0] shaped;
    logic         step;

    assign step       = tick_in & ~tick_prev & en & ~clr;
    assign phase_next = phase + N'(1);
    assign tri_val    = {phase_next[N-2:0], 1'b0};

`ifdef WAVE_GEN_SINE_EN
    localparam int Q = 2 ** (N - 2);

    function automatic int sine_point(input int i);
        real amp;
        amp = (2.0 ** (N - 1)) - 0.5;
        return int'(amp + amp * $sin(2.0 * 3.14159265358979 * i / (2.0 ** N)));
    endfunction

    logic [N-1:0] rom [Q];
    logic [1:0]   quad;
    logic [N-3:0] idx;
    logic [N-3:0] mir;
    logic [N-1:0] sine_val;

    for (genvar g = 0; g < Q; g++) begin : g_rom
        assign rom[g] = N'(sine_point(g));
    end

    assign quad = phase_next[N-1:N-2];
    assign idx  = phase_next[N-3:0];
    assign mir  = -idx;

    // Quadrant boundaries fall outside the stored quarter, so idx==0 is resolved directly.
    always_comb begin
        sine_val = '0;
        case (quad)
            2'd0:    sine_val = rom[idx];
            2'd1:    sine_val = (idx == '0) ? '1 : rom[mir];
            2'd2:    sine_val = (idx == '0) ? rom[0] : ~rom[idx];
            default: sine_val = (idx == '0) ? '0 : ~rom[mir];
        endcase
    end
`endif

    always_comb begin
        shaped = '0;
        case (wave_sel)
            2'b00:   shaped = phase_next;
            2'b01:   shaped = phase_next[N-1] ? ~tri_val : tri_val;
            2'b10:   shaped = phase_next[N-1] ? '0 : '1;
`ifdef WAVE_GEN_SINE_EN
            default: shaped = sine_val;
`else
            default: shaped = ~phase_next;
`endif
        endcase
    end

    // tick_prev resets high so a tick already asserted at reset release is not an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_prev    <= 1'b1;
            phase        <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
            phase_wrap   <= 1'b0;
        end else begin
            tick_prev    <= tick_in;
            sample_valid <= 1'b0;
            phase_wrap   <= 1'b0;
            if (clr) begin
                phase  <= '0;
                sample <= '0;
            end else if (step) begin
                phase        <= phase_next;
                sample       <= shaped;
                sample_valid <= 1'b1;
                phase_wrap   <= (phase == '1);
            end
        end
    end

endmodule

// File: tb/tb_wave_generator.sv
// tb/tb_wave_generator.sv - Directed self-checking bench for wave_generator (N=8).
module tb_wave_generator;

    localparam int N = 8;
`ifdef WAVE_GEN_SINE_EN
    localparam logic [N-1:0] SEL3_AT_40 = 8'hFF;
`else
    localparam logic [N-1:0] SEL3_AT_40 = 8'hBF;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         tick_in;
    logic         en;
    logic         clr;
    logic [1:0]   wave_sel;
    logic [N-1:0] sample;
    logic         sample_valid;
    logic         phase_wrap;

    int errors = 0;
    int checks = 0;
    int pulses;

    always #5 clk = ~clk;

    wave_generator #(.N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .tick_in      (tick_in),
        .en           (en),
        .clr          (clr),
        .wave_sel     (wave_sel),
        .sample       (sample),
        .sample_valid (sample_valid),
        .phase_wrap   (phase_wrap)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge with tick_in low; raises tick for one rising edge.
    task automatic tick(input logic [N-1:0] exp_s, input logic exp_w, input bit do_chk, input string tag);
        tick_in = 1'b1;
        @(negedge clk);
        if (do_chk) begin
            chk({tag, "_valid"}, 32'(sample_valid), 32'd1);
            chk({tag, "_sample"}, 32'(sample), 32'(exp_s));
            chk({tag, "_wrap"}, 32'(phase_wrap), 32'(exp_w));
        end
        tick_in = 1'b0;
        @(negedge clk);
        if (do_chk) begin
            chk({tag, "_valid_drop"}, 32'(sample_valid), 32'd0);
            chk({tag, "_wrap_drop"}, 32'(phase_wrap), 32'd0);
            chk({tag, "_sample_hold"}, 32'(sample), 32'(exp_s));
        end
    endtask

    initial begin
        rst = 1'b1; tick_in = 1'b0; en = 1'b1; clr = 1'b0; wave_sel = 2'b00;
        #1 rst = 1'b0;
        #1;
        chk("reset_sample", 32'(sample), 32'd0);
        chk("reset_valid", 32'(sample_valid), 32'd0);
        chk("reset_wrap", 32'(phase_wrap), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_reset_sample", 32'(sample), 32'd0);
        chk("post_reset_valid", 32'(sample_valid), 32'd0);

        tick(8'h01, 1'b0, 1'b1, "saw1");
        tick(8'h02, 1'b0, 1'b1, "saw2");
        tick(8'h03, 1'b0, 1'b1, "saw3");

        for (int i = 4; i <= 255; i++) tick(N'(i), 1'b0, (i == 255), "saw_ff");
        tick(8'h00, 1'b1, 1'b1, "wrap");

        for (int i = 1; i <= 63; i++) tick(8'h00, 1'b0, 1'b0, "fill");
        wave_sel = 2'b01;
        tick(8'h80, 1'b0, 1'b1, "tri_40");
        wave_sel = 2'b11;
        repeat (3) @(negedge clk);
        chk("sel_change_hold", 32'(sample), 32'h80);
        chk("sel_change_novalid", 32'(sample_valid), 32'd0);
        wave_sel = 2'b10;
        tick(8'hFF, 1'b0, 1'b1, "sq_41");

        wave_sel = 2'b00;
        for (int i = 8'h42; i <= 8'hBF; i++) tick(8'h00, 1'b0, 1'b0, "fill");
        wave_sel = 2'b01;
        tick(8'h7F, 1'b0, 1'b1, "tri_c0");
        wave_sel = 2'b10;
        tick(8'h00, 1'b0, 1'b1, "sq_c1");

        wave_sel = 2'b00;
        tick_in = 1'b1;
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            pulses += int'(sample_valid);
        end
        chk("held_pulses", 32'(pulses), 32'd1);
        chk("held_sample", 32'(sample), 32'hC2);
        tick_in = 1'b0;
        @(negedge clk);

        en = 1'b0;
        tick_in = 1'b1;
        @(negedge clk);
        chk("en0_valid", 32'(sample_valid), 32'd0);
        en = 1'b1;
        @(negedge clk);
        chk("en0_late_valid", 32'(sample_valid), 32'd0);
        chk("en0_sample", 32'(sample), 32'hC2);
        tick_in = 1'b0;
        @(negedge clk);
        tick(8'hC3, 1'b0, 1'b1, "en_next");

        clr = 1'b1;
        @(negedge clk);
        chk("clr_sample", 32'(sample), 32'd0);
        clr = 1'b0;
        for (int i = 1; i <= 15; i++) tick(8'h00, 1'b0, 1'b0, "fill");
        tick(8'h10, 1'b0, 1'b1, "pre_clr");
        clr = 1'b1;
        tick_in = 1'b1;
        @(negedge clk);
        chk("clr_tick_sample", 32'(sample), 32'd0);
        chk("clr_tick_valid", 32'(sample_valid), 32'd0);
        chk("clr_tick_wrap", 32'(phase_wrap), 32'd0);
        clr = 1'b0;
        @(negedge clk);
        chk("clr_release_valid", 32'(sample_valid), 32'd0);
        tick_in = 1'b0;
        @(negedge clk);
        tick(8'h01, 1'b0, 1'b1, "post_clr");

        for (int i = 2; i <= 8'h54; i++) tick(8'h00, 1'b0, 1'b0, "fill");
        tick(8'h55, 1'b0, 1'b1, "pre_rst");
        tick_in = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("rst_mid_sample", 32'(sample), 32'd0);
        chk("rst_mid_valid", 32'(sample_valid), 32'd0);
        chk("rst_mid_wrap", 32'(phase_wrap), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rel_high_valid", 32'(sample_valid), 32'd0);
        chk("rel_high_sample", 32'(sample), 32'd0);
        @(negedge clk);
        chk("rel_high_valid2", 32'(sample_valid), 32'd0);
        tick_in = 1'b0;
        @(negedge clk);
        tick(8'h01, 1'b0, 1'b1, "post_rst");

        for (int i = 2; i <= 8'h3F; i++) tick(8'h00, 1'b0, 1'b0, "fill");
        wave_sel = 2'b11;
        tick(SEL3_AT_40, 1'b0, 1'b1, "sel3_40");
        wave_sel = 2'b00;
        repeat (2) @(negedge clk);
        chk("sel3_hold", 32'(sample), 32'(SEL3_AT_40));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wave_generator.md
WAVE_GENERATOR -- requirements
Module: wave_generator

Interface
REQ-001 Parameter N SHALL have default 8 and sets the phase and sample width in bits; legal values are even, 4 to 16.
REQ-002 clk  input  1  SHALL be the single clock; all state updates occur on the rising edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 tick_in  input  1  SHALL carry the divided rate signal from the upstream frequency divider's co output, synchronous to clk.
REQ-005 en  input  1  SHALL enable stepping when high.
REQ-006 clr  input  1  SHALL be a synchronous clear of phase and outputs when high.
REQ-007 wave_sel  input  2  SHALL select the waveform: 00 saw, 01 triangle, 10 square, 11 per REQ-028.
REQ-008 sample  output  N  SHALL be the registered unsigned waveform sample.
REQ-009 sample_valid  output  1  SHALL be a one-cycle pulse marking each new sample.
REQ-010 phase_wrap  output  1  SHALL be a one-cycle pulse when phase wraps from 2^N-1 to 0.

Function
REQ-011 A tick_prev register SHALL hold tick_in delayed by one clk cycle; a step SHALL occur in a cycle where tick_in=1, tick_prev=0, en=1 and clr=0.
REQ-012 tick_prev SHALL update every cycle regardless of en; a rising tick_in edge seen while en=0 SHALL be discarded, not deferred.
REQ-013 On a step, phase[N-1:0] SHALL increment by 1 modulo 2^N at the same clock edge.
REQ-014 On a step, sample SHALL be loaded at the same edge from the new phase value, giving latency of one clk edge from the detected tick_in edge.
REQ-015 Saw (00): sample = phase.
REQ-016 Triangle (01): sample = {phase[N-2:0],1'b0} when phase[N-1]=0, otherwise its bitwise inverse.
REQ-017 Square (10): sample = all ones when phase[N-1]=0, otherwise all zeros.
REQ-018 wave_sel SHALL be sampled only on step edges; a change between steps SHALL NOT alter sample until the next step.
REQ-019 sample_valid SHALL be 1 for exactly the cycle after each step edge and 0 otherwise.
REQ-020 phase_wrap SHALL be 1 for exactly the cycle after a step that moves phase from 2^N-1 to 0.
REQ-021 While tick_in is held high, only one step SHALL occur; the next step requires tick_in to return low.
REQ-022 clr=1 SHALL take priority over a coincident step: phase=0, sample=0, sample_valid=0 and phase_wrap=0 at the next edge; tick_prev SHALL still load tick_in.
REQ-023 When no step occurs and clr=0, phase and sample SHALL hold.

Reset
REQ-024 rst low SHALL immediately force phase=0, sample=0, sample_valid=0, phase_wrap=0 and tick_prev=1, independent of clk.
REQ-025 Because tick_prev resets to 1, a tick_in already high when rst releases SHALL NOT cause a step.
REQ-026 rst asserted mid-operation SHALL discard any in-flight step; the first step after release SHALL produce phase=1.

Configuration
REQ-027 The preprocessor macro WAVE_GEN_SINE_EN SHALL select the behaviour of wave_sel=11.
REQ-028 With WAVE_GEN_SINE_EN defined, wave_sel=11 SHALL output round(2^(N-1) - 0.5 + (2^(N-1) - 0.5)*sin(2*pi*phase/2^N)) from a quarter-wave ROM of 2^(N-2) entries mirrored by phase[N-1:N-2]; without it, wave_sel=11 SHALL output ~phase (falling saw) and no ROM is synthesized.

Verification
REQ-029 Saw, N=8: apply 3 isolated tick_in pulses after reset -> sample 1, 2, 3, each with one sample_valid pulse one edge after the tick edge.
REQ-030 Wrap: 256 ticks in saw mode -> sample returns to 0 with phase_wrap=1 for one cycle; triangle at phase 0x40 -> 0x80, at phase 0xC0 -> 0x7F.
REQ-031 Held tick: tick_in high 10 cycles -> exactly one step; tick edge with en=0 -> no step, and the next enabled edge steps by 1 only.
REQ-032 clr coincident with a tick edge at phase 0x10 -> phase=0, sample=0, sample_valid=0.
REQ-033 Async reset mid-run at phase 0x55, then release with tick_in high -> all outputs 0 immediately, no step until tick_in falls and rises again.
REQ-034 wave_sel=11, phase 0x40: with WAVE_GEN_SINE_EN defined -> 0xFF; without it -> 0xBF.
